// File: rtl/btn_irq_ctrl_pkg.sv
// Shared types and constants for the button interrupt controller.
package btn_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [7:0] VEC_SRC0 = 8'd2;
  localparam logic [7:0] VEC_SRC1 = 8'd4;
  localparam logic [7:0] VEC_SRC2 = 8'd6;

  // Bit positions inside the CPU button register
  localparam int unsigned BIT_BTN0 = 4;
  localparam int unsigned BIT_A    = 3;
  localparam int unsigned BIT_B    = 2;
  localparam int unsigned BIT_SRC0 = 7;
  localparam int unsigned BIT_SRC1 = 4;
  localparam int unsigned BIT_SRC2 = 3;

  localparam int unsigned NUM_SRC = 3;

  // Highest-priority pending source: src2 > src1 > src0
  function automatic logic [1:0] pick_src(input logic [NUM_SRC-1:0] pend);
    if (pend[2])      return 2'd2;
    else if (pend[1]) return 2'd1;
    else              return 2'd0;
  endfunction

  function automatic logic [7:0] src_vec(input logic [1:0] src);
    case (src)
      2'd2:    return VEC_SRC2;
      2'd1:    return VEC_SRC1;
      default: return VEC_SRC0;
    endcase
  endfunction

endpackage

// File: rtl/btn_irq_ctrl_debounce.sv
// One button: two-flop synchronizer, tick-sampled stability counter, debounced level.
module btn_debounce #(
  parameter int unsigned DEB_TICKS = 4,
  parameter int unsigned TICK_W    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw_n,
  output logic level
);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              level_q, level_d;

  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick) begin
      if ((!sync2_q) != level_q) begin
        // The DEB_TICKS-th consecutive differing sample flips the level
        if (cnt_q == TICK_W'(DEB_TICKS - 1)) begin
          level_d = !level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TICK_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_irq_ctrl.sv
// Button register plus a three-source prioritized interrupt controller.
module btn_irq_ctrl
  import btn_irq_ctrl_pkg::*;
#(
  parameter int unsigned DEB_TICKS = 4,
  parameter int unsigned TICK_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] btn_n,
  input  logic       abtn_n,
  input  logic       bbtn_n,
  input  logic       irq_ack,
  input  logic       irq_eoi,
  output logic [7:0] btn_state,
  output logic       irq_req,
  output logic [7:0] irq_vec,
  output logic [2:0] pending
);

  localparam int unsigned NUM_IN = 6;

  logic [NUM_IN-1:0]  raw_n;
  logic [NUM_IN-1:0]  level;
  logic [NUM_SRC-1:0] src_lvl;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] ack_clr;

  state_e             state_q, state_d;
  logic [1:0]         src_q, src_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               irq_req_q, irq_req_d;
  logic [7:0]         irq_vec_q, irq_vec_d;

  assign raw_n = {bbtn_n, abtn_n, btn_n};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    btn_debounce #(
      .DEB_TICKS(DEB_TICKS),
      .TICK_W   (TICK_W)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw_n(raw_n[i]),
      .level(level[i])
    );
  end

  always_comb begin
    btn_state                 = 8'd0;
    btn_state[BIT_BTN0 +: 4]  = level[3:0];
    btn_state[BIT_A]          = level[4];
    btn_state[BIT_B]          = level[5];
  end

  assign src_lvl  = {btn_state[BIT_SRC2], btn_state[BIT_SRC1], btn_state[BIT_SRC0]};
  assign src_rise = src_lvl & ~prev_q;

  // Next state, pending bookkeeping and registered request outputs
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    ack_clr = '0;
    prev_d  = src_lvl;
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          state_d = REQ;
          src_d   = pick_src(pending_q);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = SERVICE;
          ack_clr = NUM_SRC'(1) << src_q;
        end
      end
      SERVICE: begin
        if (irq_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A rise on the ack cycle wins over the clear
    pending_d = (pending_q & ~ack_clr) | src_rise;
    irq_req_d = (state_d == REQ);
    irq_vec_d = (state_d == REQ) ? src_vec(src_d) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= 2'd0;
      prev_q    <= '0;
      pending_q <= '0;
      irq_req_q <= 1'b0;
      irq_vec_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      irq_req_q <= irq_req_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  assign irq_req = irq_req_q;
  assign irq_vec = irq_vec_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Directed bench for btn_irq_ctrl with a cycle-level reference model.
module tb_btn_irq_ctrl;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] btn_n;
  logic       abtn_n;
  logic       bbtn_n;
  logic       irq_ack;
  logic       irq_eoi;
  logic [7:0] btn_state;
  logic       irq_req;
  logic [7:0] irq_vec;
  logic [2:0] pending;

  btn_irq_ctrl #(.DEB_TICKS(4), .TICK_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn_n    (btn_n),
    .abtn_n   (abtn_n),
    .bbtn_n   (bbtn_n),
    .irq_ack  (irq_ack),
    .irq_eoi  (irq_eoi),
    .btn_state(btn_state),
    .irq_req  (irq_req),
    .irq_vec  (irq_vec),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int tcnt = 0;
  bit chk_en = 0;
  bit seen_act = 0;

  // Reference model state; inputs index 0..3 = btn[0..3], 4 = A, 5 = B
  bit       m_s1 [6];
  bit       m_s2 [6];
  int       m_cnt[6];
  bit       m_lvl[6];
  bit       m_lvl_d[6];
  bit [2:0] m_pend;
  int       m_state;   // 0 idle, 1 request, 2 service
  int       m_src;
  bit       m_req;
  bit [7:0] m_vec;

  function automatic int src_idx(input int k);
    if (k == 0) return 3;
    else if (k == 1) return 0;
    else return 4;
  endfunction

  function automatic bit [7:0] vec_of(input int k);
    return 8'(2 * (k + 1));
  endfunction

  function automatic bit raw_of(input int i);
    if (i < 4) return btn_n[i];
    else if (i == 4) return abtn_n;
    else return bbtn_n;
  endfunction

  function automatic bit [7:0] model_btn();
    bit [7:0] v;
    v = 8'd0;
    for (int i = 0; i < 4; i++) v[4 + i] = m_lvl[i];
    v[3] = m_lvl[4];
    v[2] = m_lvl[5];
    return v;
  endfunction

  always @(posedge clk) begin
    bit [2:0] rise;
    bit [2:0] clr;
    int ns;
    int nsrc;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_lvl[i] = 0; m_lvl_d[i] = 0;
      end
      m_pend = 0; m_state = 0; m_src = 0; m_req = 0; m_vec = 0;
    end else begin
      rise = 0;
      for (int k = 0; k < 3; k++)
        if (m_lvl[src_idx(k)] && !m_lvl_d[src_idx(k)]) rise[k] = 1;
      clr = 0; ns = m_state; nsrc = m_src;
      if (m_state == 0 && m_pend != 0) begin
        ns = 1;
        nsrc = m_pend[2] ? 2 : (m_pend[1] ? 1 : 0);
      end else if (m_state == 1 && irq_ack) begin
        ns = 2;
        clr[m_src] = 1;
      end else if (m_state == 2 && irq_eoi) begin
        ns = 0;
      end
      m_pend  = (m_pend & ~clr) | rise;
      m_state = ns;
      m_src   = nsrc;
      m_req   = (ns == 1);
      m_vec   = m_req ? vec_of(nsrc) : 8'd0;
      for (int i = 0; i < 6; i++) begin
        m_lvl_d[i] = m_lvl[i];
        if (tick) begin
          if ((m_s2[i] == 0) != m_lvl[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DEB) begin
              m_lvl[i] = !m_lvl[i];
              m_cnt[i] = 0;
            end
          end else begin
            m_cnt[i] = 0;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw_of(i);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model btn_state", btn_state, model_btn());
      check("model irq_req", {7'd0, irq_req}, {7'd0, m_req});
      check("model irq_vec", irq_vec, m_vec);
      check("model pending", {5'd0, pending}, {5'd0, m_pend});
    end
    if (irq_req || btn_state != 8'd0) seen_act = 1;
  end

  task automatic cyc();
    @(negedge clk);
    tcnt++;
    tick = (tcnt % 4 == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Advance until just after the next tick edge
  task automatic period();
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin cyc(); n++; end
    cyc();
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (irq_req !== 1'b1 && n < 200) begin cyc(); n++; end
    check(name, {7'd0, irq_req}, 8'd1);
  endtask

  task automatic pulse_ack();
    irq_ack = 1; cyc(); irq_ack = 0;
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1; cyc(); irq_eoi = 0;
  endtask

  initial begin
    int n;
    rst = 1; tick = 0; btn_n = 4'hF; abtn_n = 1; bbtn_n = 1; irq_ack = 0; irq_eoi = 0;
    run(3);
    chk_en = 1;
    check("reset btn_state", btn_state, 8'd0);
    check("reset irq_req", {7'd0, irq_req}, 8'd0);
    check("reset irq_vec", irq_vec, 8'd0);
    check("reset pending", {5'd0, pending}, 8'd0);
    rst = 0;
    run(12);

    // Stray ack/eoi in IDLE have no effect
    pulse_ack(); pulse_eoi(); cyc();
    check("stray ack irq_req", {7'd0, irq_req}, 8'd0);

    // Bounce on A, then four stable low ticks
    period();
    for (int k = 0; k < 10; k++) begin
      abtn_n = (k % 2 == 0) ? 1'b0 : 1'b1;
      period();
    end
    abtn_n = 0;
    for (int k = 0; k < 4; k++) begin
      period();
      if (k < 3) begin
        check("bounce btn_state early", btn_state, 8'h00);
        check("bounce pending early", {5'd0, pending}, 8'd0);
      end
    end
    check("bounce btn_state", btn_state, 8'h08);
    check("bounce pending before set", {5'd0, pending}, 8'd0);
    cyc();
    check("bounce pending set", {5'd0, pending}, 8'h04);
    check("latency irq_req idle", {7'd0, irq_req}, 8'd0);
    cyc();
    check("latency irq_req", {7'd0, irq_req}, 8'd1);
    check("bounce irq_vec", irq_vec, 8'd6);
    pulse_ack(); pulse_eoi();
    abtn_n = 1;
    run(40);
    check("bounce pending cleared", {5'd0, pending}, 8'd0);

    // Simultaneous src0 + src2 (+ non-source B)
    btn_n[3] = 0; abtn_n = 0; bbtn_n = 0;
    wait_req("simul req1");
    check("simul vec first", irq_vec, 8'd6);
    check("simul pending", {5'd0, pending}, 8'h05);
    pulse_ack();
    check("simul service irq_req", {7'd0, irq_req}, 8'd0);
    pulse_eoi();
    wait_req("simul req2");
    check("simul vec second", irq_vec, 8'd2);
    pulse_ack(); pulse_eoi();
    btn_n = 4'hF; abtn_n = 1; bbtn_n = 1;
    run(40);
    check("simul pending final", {5'd0, pending}, 8'd0);
    check("simul btn_state final", btn_state, 8'd0);

    // Hold off the ack for 50 cycles
    btn_n[0] = 0;
    wait_req("hold req");
    for (int k = 0; k < 50; k++) begin
      cyc();
      check("hold irq_req", {7'd0, irq_req}, 8'd1);
      check("hold irq_vec", irq_vec, 8'd4);
    end

    // Re-press of src1 landing on its ack cycle
    btn_n[0] = 1;
    run(30);
    btn_n[0] = 0;
    n = 0;
    while (!(m_lvl[0] && !m_lvl_d[0]) && n < 100) begin cyc(); n++; end
    check("repress rise found", 8'(n < 100), 8'd1);
    pulse_ack();
    check("repress pending kept", {5'd0, pending}, 8'h02);
    check("repress service", {7'd0, irq_req}, 8'd0);
    pulse_eoi();
    wait_req("repress req");
    check("repress vec", irq_vec, 8'd4);
    pulse_ack(); pulse_eoi();
    btn_n[0] = 1;
    run(40);
    check("repress pending final", {5'd0, pending}, 8'd0);

    // Reset while requesting with two sources pending
    btn_n[3] = 0; abtn_n = 0;
    wait_req("rst req");
    check("rst pre pending", {5'd0, pending}, 8'h05);
    rst = 1; btn_n = 4'hF; abtn_n = 1;
    cyc();
    check("rst irq_req", {7'd0, irq_req}, 8'd0);
    check("rst pending", {5'd0, pending}, 8'd0);
    check("rst btn_state", btn_state, 8'd0);
    check("rst irq_vec", irq_vec, 8'd0);
    rst = 0;
    run(30);
    check("rst no residual", {5'd0, pending}, 8'd0);
    check("rst no req", {7'd0, irq_req}, 8'd0);

    // Glitch shorter than the debounce window
    period();
    btn_n[0] = 0;
    seen_act = 0;
    period(); period();
    btn_n[0] = 1;
    run(40);
    check("glitch no activity", 8'(seen_act), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
